// File: rtl/bcd_countdown_timer.sv
// BCD mm:ss countdown timer with load/start/stop control and a tick-counted alarm.
// Digits and status flags are plain registers, so every output is glitch-free.
module bcd_countdown_timer #(
    parameter int unsigned ALARM_TICKS = 10
) (
    input  logic       clk,
    input  logic       cr,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] pre_m10,
    input  logic [3:0] pre_m1,
    input  logic [3:0] pre_s10,
    input  logic [3:0] pre_s1,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] m10,
    output logic [3:0] m1,
    output logic [3:0] s10,
    output logic [3:0] s1,
    output logic       running,
    output logic       alarm,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    // Alarm leaves EXPIRED on the tick that would make the count reach ALARM_TICKS.
    localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

    state_t     state;
    logic [7:0] alarm_cnt;
    logic       count_zero;
    logic       last_sec;

    assign count_zero = (m10 == 4'd0) && (m1 == 4'd0) && (s10 == 4'd0) && (s1 == 4'd0);
    // The next decrement lands on 00:00.
    assign last_sec   = (m10 == 4'd0) && (m1 == 4'd0) && (s10 == 4'd0) && (s1 == 4'd1);

    // Out-of-range preset digits saturate to the digit's legal maximum.
    function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] mx);
        return (d > mx) ? mx : d;
    endfunction

    // Whole controller: priority cr > load > stop > start > tick, flags registered with state.
    always_ff @(posedge clk) begin
        if (!cr) begin
            state     <= IDLE;
            m10       <= 4'd0;
            m1        <= 4'd0;
            s10       <= 4'd0;
            s1        <= 4'd0;
            running   <= 1'b0;
            alarm     <= 1'b0;
            done      <= 1'b0;
            alarm_cnt <= 8'd0;
        end else begin
            done <= 1'b0;
            if (load) begin
                m10       <= clamp(pre_m10, 4'd5);
                m1        <= clamp(pre_m1, 4'd9);
                s10       <= clamp(pre_s10, 4'd5);
                s1        <= clamp(pre_s1, 4'd9);
                state     <= IDLE;
                running   <= 1'b0;
                alarm     <= 1'b0;
                alarm_cnt <= 8'd0;
            end else if (stop) begin
                // stop is consumed in every state; it only acts in RUN and EXPIRED
                if (state == RUN) begin
                    state   <= PAUSE;
                    running <= 1'b0;
                end else if (state == EXPIRED) begin
                    state     <= IDLE;
                    alarm     <= 1'b0;
                    alarm_cnt <= 8'd0;
                end
            end else if (start && (state == IDLE || state == PAUSE) && !count_zero) begin
                state   <= RUN;
                running <= 1'b1;
            end else if (tick) begin
                if (state == RUN) begin
                    // Borrow chain; a RUN count is never 00:00 so m10 cannot underflow.
                    if (s1 != 4'd0) begin
                        s1 <= s1 - 4'd1;
                    end else begin
                        s1 <= 4'd9;
                        if (s10 != 4'd0) begin
                            s10 <= s10 - 4'd1;
                        end else begin
                            s10 <= 4'd5;
                            if (m1 != 4'd0) begin
                                m1 <= m1 - 4'd1;
                            end else begin
                                m1  <= 4'd9;
                                m10 <= m10 - 4'd1;
                            end
                        end
                    end
                    if (last_sec) begin
                        state     <= EXPIRED;
                        running   <= 1'b0;
                        alarm     <= 1'b1;
                        done      <= 1'b1;
                        alarm_cnt <= 8'd0;
                    end
                end else if (state == EXPIRED) begin
                    if (alarm_cnt == ALARM_LAST) begin
                        state     <= IDLE;
                        alarm     <= 1'b0;
                        alarm_cnt <= 8'd0;
                    end else begin
                        alarm_cnt <= alarm_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench: a seconds-based reference model predicts each cycle's outputs,
// a monitor pops the prediction after every rising edge and compares.
module tb_bcd_countdown_timer;

    localparam int ALARM_TICKS = 10;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;

    logic       clk = 1'b0;
    logic       cr = 1'b0, tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
    logic [3:0] pre_m10 = 4'd0, pre_m1 = 4'd0, pre_s10 = 4'd0, pre_s1 = 4'd0;
    logic [3:0] m10, m1, s10, s1;
    logic       running, alarm, done;

    bcd_countdown_timer #(.ALARM_TICKS(ALARM_TICKS)) dut (
        .clk(clk), .cr(cr), .tick(tick), .load(load),
        .pre_m10(pre_m10), .pre_m1(pre_m1), .pre_s10(pre_s10), .pre_s1(pre_s1),
        .start(start), .stop(stop),
        .m10(m10), .m1(m1), .s10(s10), .s1(s1),
        .running(running), .alarm(alarm), .done(done)
    );

    always #5 clk = ~clk;

    // reference model state: count kept as total seconds
    int secs = 0, st = S_IDLE, acnt = 0;
    bit mdone = 0;
    logic [18:0] expq[$];
    int vecs = 0, errs = 0;

    function automatic int clampi(input int d, input int mx);
        return (d > mx) ? mx : d;
    endfunction

    function automatic logic [18:0] pack_exp();
        int m, s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                st == S_RUN, st == S_EXP, mdone};
    endfunction

    // Drive one cycle of inputs, advance the model through the coming edge, queue the prediction.
    task automatic apply(input bit c, input bit ld, input int a, input int b, input int d, input int e,
                         input bit sa, input bit sp, input bit tk);
        @(negedge clk);
        cr = c; load = ld; start = sa; stop = sp; tick = tk;
        pre_m10 = 4'(a); pre_m1 = 4'(b); pre_s10 = 4'(d); pre_s1 = 4'(e);
        mdone = 0;
        if (!c) begin
            st = S_IDLE; secs = 0; acnt = 0;
        end else if (ld) begin
            secs = clampi(a, 5) * 600 + clampi(b, 9) * 60 + clampi(d, 5) * 10 + clampi(e, 9);
            st = S_IDLE; acnt = 0;
        end else if (sp) begin
            if (st == S_RUN) st = S_PAUSE;
            else if (st == S_EXP) begin st = S_IDLE; acnt = 0; end
        end else if (sa && (st == S_IDLE || st == S_PAUSE) && secs != 0) begin
            st = S_RUN;
        end else if (tk) begin
            if (st == S_RUN) begin
                secs = secs - 1;
                if (secs == 0) begin st = S_EXP; mdone = 1; acnt = 0; end
            end else if (st == S_EXP) begin
                acnt = acnt + 1;
                if (acnt == ALARM_TICKS) begin st = S_IDLE; acnt = 0; end
            end
        end
        expq.push_back(pack_exp());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic ld(input int a, input int b, input int d, input int e);
        apply(1, 1, a, b, d, e, 0, 0, 0);
    endtask
    task automatic go();
        apply(1, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) apply(1, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Monitor: every edge produces an output word; compare against the oldest prediction.
    always @(posedge clk) begin
        logic [18:0] exp_v, act_v;
        #1;
        if (expq.size() != 0) begin
            exp_v = expq.pop_front();
            act_v = {m10, m1, s10, s1, running, alarm, done};
            vecs++;
            if (act_v !== exp_v) begin
                errs++;
                $display("FAIL cycle_out t=%0t got %h%h:%h%h run=%b alm=%b done=%b expected %h%h:%h%h run=%b alm=%b done=%b",
                         $time, act_v[18:15], act_v[14:11], act_v[10:7], act_v[6:3], act_v[2], act_v[1], act_v[0],
                         exp_v[18:15], exp_v[14:11], exp_v[10:7], exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    end

    initial begin
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // borrow chain 10:00 -> 09:59
        ld(1, 0, 0, 0); go(); ticks(1); idle(1);
        // expiry then auto-clear after ALARM_TICKS ticks
        ld(0, 0, 0, 2); go(); ticks(2); idle(2); ticks(ALARM_TICKS); idle(2);
        // pause with simultaneous stop+tick, resume
        ld(0, 1, 0, 0); go(); ticks(3);
        apply(1, 0, 0, 0, 0, 0, 0, 1, 1);
        ticks(2); go(); ticks(1); idle(1);
        // clamp, then start on 00:00 ignored
        ld(7, 12, 9, 4); idle(1); ld(0, 0, 0, 0); go(); ticks(1); idle(1);
        // reset mid-run together with tick and load
        ld(0, 5, 3, 1); go(); ticks(1);
        apply(0, 1, 3, 3, 3, 3, 1, 0, 1); idle(1);
        // alarm acknowledge by stop
        ld(0, 0, 0, 1); go(); ticks(1); idle(1);
        apply(1, 0, 0, 0, 0, 0, 0, 1, 0); ticks(2);
        // randomized traffic, presets biased toward short counts so expiry happens often
        for (int i = 0; i < 3000; i++) begin
            bit c, l, sa, sp, tk;
            int a, b, d, e;
            c  = ($urandom_range(0, 199) != 0);
            l  = ($urandom_range(0, 39) == 0);
            sp = ($urandom_range(0, 24) == 0);
            sa = ($urandom_range(0, 9) == 0);
            tk = sa ? 1'b0 : ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1) begin
                a = 0; b = 0; d = $urandom_range(0, 1); e = $urandom_range(0, 15);
            end else begin
                a = $urandom_range(0, 15); b = $urandom_range(0, 15);
                d = $urandom_range(0, 15); e = $urandom_range(0, 15);
            end
            apply(c, l, a, b, d, e, sa, sp, tk);
        end
        idle(1);
        for (int i = 0; i < 10 && expq.size() != 0; i++) @(posedge clk);
        #2;
        if (expq.size() != 0) begin
            errs++;
            $display("FAIL drain pending=%0d expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 Parameter: ALARM_TICKS, default 10, number of tick pulses alarm stays high after expiry (range 1..255).
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: cr  input  1  reset, synchronous, active-low; sampled on rising clk only.
REQ-004 Port: tick  input  1  one-cycle enable pulse (1 Hz from the clock divider); the count advances only on cycles with tick=1.
REQ-005 Port: load  input  1  level, sampled per cycle; copies the preset digits into the count.
REQ-006 Port: pre_m10  input  4  preset minutes-tens BCD digit, legal 0..5.
REQ-007 Port: pre_m1  input  4  preset minutes-ones BCD digit, legal 0..9.
REQ-008 Port: pre_s10  input  4  preset seconds-tens BCD digit, legal 0..5.
REQ-009 Port: pre_s1  input  4  preset seconds-ones BCD digit, legal 0..9.
REQ-010 Port: start  input  1  begins or resumes the countdown.
REQ-011 Port: stop  input  1  pauses the countdown; also clears the alarm.
REQ-012 Port: m10, m1, s10, s1  output  4 each  current count as BCD digits, registered.
REQ-013 Port: running  output  1  high while in RUN.
REQ-014 Port: done  output  1  one-cycle pulse on reaching 00:00.
REQ-015 Port: alarm  output  1  high while in EXPIRED.

Function
REQ-016 States SHALL be IDLE, RUN, PAUSE and EXPIRED, encoded in one state register.
REQ-017 Per-cycle priority SHALL be cr > load > stop > start > tick.
REQ-018 load SHALL, in any state, write the preset digits to the count and enter IDLE on the same edge.
REQ-019 A preset digit above its legal maximum SHALL be clamped on load: m10/s10 values above 5 load as 5; m1/s1 values above 9 load as 9.
REQ-020 IDLE or PAUSE with start=1 and a count other than 00:00 SHALL enter RUN on the next edge.
REQ-021 start with a count of 00:00 SHALL be ignored, and the state SHALL stay unchanged.
REQ-022 RUN with stop=1 SHALL enter PAUSE, and the count SHALL hold.
REQ-023 start in RUN and stop in IDLE or PAUSE SHALL have no effect.
REQ-024 RUN with tick=1 SHALL decrement the count by one second on that edge; latency is 0 cycles to the visible digits.
REQ-025 Decrement rule: s1 decrements.
REQ-026 When s1 is 0, s1 SHALL become 9 and s10 SHALL decrement.
REQ-027 When s10 is 0, s10 SHALL become 5 and m1 SHALL decrement.
REQ-028 When m1 is 0, m1 SHALL become 9 and m10 SHALL decrement.
REQ-029 No digit SHALL ever hold a non-BCD value or exceed its legal maximum.
REQ-030 The decrement that produces 00:00 SHALL, on the same edge, enter EXPIRED and set done=1 for exactly one cycle.
REQ-031 EXPIRED SHALL hold the count at 00:00, and tick SHALL not change the digits.
REQ-032 EXPIRED SHALL count ALARM_TICKS tick pulses with an 8-bit counter; on the edge that samples the ALARM_TICKS-th tick it SHALL enter IDLE.
REQ-033 stop in EXPIRED SHALL enter IDLE on the next edge, acknowledging the alarm.
REQ-034 load in EXPIRED SHALL load the presets and enter IDLE on the next edge.
REQ-035 tick in IDLE or PAUSE SHALL be ignored.
REQ-036 tick, start and stop arriving in the same cycle SHALL resolve per REQ-017: stop wins, and no decrement occurs that cycle.
REQ-037 running SHALL be 1 exactly when the state is RUN.
REQ-038 alarm SHALL be 1 exactly when the state is EXPIRED.
REQ-039 done SHALL be 0 in every cycle other than the one defined in REQ-030.

Reset
REQ-040 cr=0 at a rising edge SHALL force state IDLE; m10=m1=s10=s1=0; running=alarm=done=0; alarm counter=0.
REQ-041 cr SHALL override all other inputs, including in mid-RUN and mid-EXPIRED; there is no asynchronous path.
REQ-042 Outputs before the first cr pulse are unspecified; the bench SHALL apply cr=0 for at least 1 cycle.

Verification
REQ-043 Borrow chain: load 10:00, start, 1 tick -> 09:59, running=1.
REQ-044 Expiry and auto-clear: load 00:02, start, 2 ticks -> 00:00 with done high for 1 cycle, alarm=1; 10 further ticks -> alarm=0, state IDLE.
REQ-045 Pause/resume with simultaneous inputs: load 01:00, start, 3 ticks -> 00:57; stop and tick in the same cycle -> still 00:57, running=0; start, 1 tick -> 00:56.
REQ-046 Clamp and invalid start: load pre_m10=7, pre_m1=12, pre_s10=9, pre_s1=4 -> 59:54; load 00:00, start -> state IDLE, running=0.
REQ-047 Reset mid-run: during RUN at 05:30, drive cr=0 for 1 cycle together with tick and load -> 00:00, IDLE, all flags 0 on the next edge.
REQ-048 Alarm acknowledge: in EXPIRED, stop=1 -> alarm=0 on the next edge, count remains 00:00.
